// File: rtl/mccoy_core_param.sv
// mccoy_core_param: parametrised accumulator core with register file, NZCV flags,
// optional saturating ADD/SUB and a combinational debug read port.
module mccoy_core_param #(
  parameter int DATA_W   = 8,
  parameter int IMM_W    = 3,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [IMM_W+2:0]  instr,
  input  logic [IMM_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] acc_out,
  output logic [3:0]        flags
);
  localparam logic [2:0] OP_LI  = 3'b000;
  localparam logic [2:0] OP_LR  = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_LIH = 3'b101;
  localparam logic [2:0] OP_SR  = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;
  localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] S_MAX = ~S_MIN;

  logic [DATA_W-1:0] r_regs [2**IMM_W];
  logic [DATA_W-1:0] r_acc;
  logic [3:0]        r_flags;

  logic [2:0]        w_op;
  logic [IMM_W-1:0]  w_opnd;
  logic [DATA_W-1:0] w_r, w_b, w_res, w_sat, w_acc_nx, w_nz_src;
  logic [DATA_W:0]   w_sum;
  logic              w_is_sub, w_arith, w_v;
  logic [3:0]        w_flags_nx;

  assign w_op     = instr[2:0];
  assign w_opnd   = instr[IMM_W+2:3];
  assign w_r      = (w_opnd == '0) ? '0 : r_regs[w_opnd];
  assign w_is_sub = (w_op == OP_SUB) || (w_op == OP_CMP);
  assign w_arith  = w_is_sub || (w_op == OP_ADD);

  // Subtraction as acc + ~R + 1, so the carry out is the no-borrow flag.
  assign w_b   = w_is_sub ? ~w_r : w_r;
  assign w_sum = {1'b0, r_acc} + {1'b0, w_b} + {{DATA_W{1'b0}}, w_is_sub};
  assign w_res = w_sum[DATA_W-1:0];
  assign w_v   = (r_acc[DATA_W-1] == w_b[DATA_W-1]) && (w_res[DATA_W-1] != r_acc[DATA_W-1]);
  assign w_sat = (SATURATE != 0 && w_v) ? (r_acc[DATA_W-1] ? S_MIN : S_MAX) : w_res;

  always_comb begin
    w_acc_nx = (w_op == OP_LI)  ? {{(DATA_W-IMM_W){w_opnd[IMM_W-1]}}, w_opnd} :
               (w_op == OP_LR)  ? w_r :
               (w_op == OP_SUB || w_op == OP_ADD) ? w_sat :
               (w_op == OP_NOT) ? ~r_acc :
               (w_op == OP_LIH) ? {r_acc[DATA_W-IMM_W-1:0], w_opnd} :
               r_acc;
    w_nz_src = (w_op == OP_CMP) ? w_res : w_acc_nx;
    w_flags_nx = (w_op == OP_SR) ? r_flags :
                 {w_nz_src[DATA_W-1], w_nz_src == '0,
                  w_arith ? {w_sum[DATA_W], w_v} : r_flags[1:0]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc   <= '0;
      r_flags <= '0;
      for (int i = 0; i < 2**IMM_W; i++) r_regs[i] <= '0;
    end else if (instr_valid) begin
      r_acc   <= w_acc_nx;
      r_flags <= w_flags_nx;
      if (w_op == OP_SR && w_opnd != '0) r_regs[w_opnd] <= r_acc;
    end
  end

  assign dbg_data = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];
  assign acc_out  = r_acc;
  assign flags    = r_flags;
endmodule

// File: tb/tb_mccoy_core_param.sv
// tb_mccoy_core_param: scoreboard bench for wrapping, saturating and 12-bit core variants.
module tb_mccoy_core_param;
  localparam logic [2:0] LI = 3'd0, LR = 3'd1, SUB = 3'd2, ADD = 3'd3;
  localparam logic [2:0] NOT = 3'd4, LIH = 3'd5, SR = 3'd6, CMP = 3'd7;

  typedef struct {
    int          tgt;
    int          id;
    logic [11:0] a0;
    logic [3:0]  f0;
    logic [11:0] a1;
    logic [3:0]  f1;
    bit          dchk;
    logic [11:0] d;
  } exp_t;

  logic clk = 0, reset = 0;
  bit   run = 0, chk = 0;
  int   errs = 0, checks = 0, nid = 0;
  exp_t q[$];

  logic       v8 = 0;
  logic [5:0] in8 = '0;
  logic [2:0] da8 = '0;
  logic [7:0] dd0, dd1, a0, a1;
  logic [3:0] f0, f1;
  logic        v12 = 0;
  logic [6:0]  in12 = '0;
  logic [3:0]  da12 = '0;
  logic [11:0] dd2, a2;
  logic [3:0]  f2;

  mccoy_core_param #(.DATA_W(8), .IMM_W(3), .SATURATE(0)) dut0 (
    .clk(clk), .reset(reset), .instr_valid(v8), .instr(in8), .dbg_addr(da8),
    .dbg_data(dd0), .acc_out(a0), .flags(f0));
  mccoy_core_param #(.DATA_W(8), .IMM_W(3), .SATURATE(1)) dut1 (
    .clk(clk), .reset(reset), .instr_valid(v8), .instr(in8), .dbg_addr(da8),
    .dbg_data(dd1), .acc_out(a1), .flags(f1));
  mccoy_core_param #(.DATA_W(12), .IMM_W(4), .SATURATE(0)) dut2 (
    .clk(clk), .reset(reset), .instr_valid(v12), .instr(in12), .dbg_addr(da12),
    .dbg_data(dd2), .acc_out(a2), .flags(f2));

  always #5 if (run) clk = ~clk;

  task automatic check(input string n, input int id, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s (step %0d): got %h expected %h", n, id, act, exp);
    end
  endtask

  task automatic s8(input bit v, input logic [2:0] op, input logic [2:0] opnd, input logic [2:0] da,
                    input logic [7:0] ea0, input logic [3:0] ef0, input logic [7:0] ea1,
                    input logic [3:0] ef1, input bit dchk, input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    v8 = v; in8 = {opnd, op}; da8 = da; v12 = 0; chk = 1;
    e.tgt = 0; e.id = nid++; e.a0 = {4'h0, ea0}; e.f0 = ef0; e.a1 = {4'h0, ea1}; e.f1 = ef1;
    e.dchk = dchk; e.d = {4'h0, d};
    q.push_back(e);
  endtask

  task automatic s(input logic [2:0] op, input logic [2:0] opnd, input logic [7:0] a, input logic [3:0] f);
    s8(1, op, opnd, 3'd0, a, f, a, f, 0, 8'h00);
  endtask

  task automatic s12(input logic [2:0] op, input logic [3:0] opnd, input logic [11:0] a, input logic [3:0] f);
    exp_t e;
    @(negedge clk);
    v8 = 0; v12 = 1; in12 = {opnd, op}; chk = 1;
    e.tgt = 1; e.id = nid++; e.a0 = a; e.f0 = f; e.a1 = '0; e.f1 = '0; e.dchk = 0; e.d = '0;
    q.push_back(e);
  endtask

  task automatic drain();
    @(negedge clk);
    v8 = 0; v12 = 0; chk = 0;
    @(posedge clk);
    #2;
  endtask

  // Monitor: every clock tagged by the stimulus owes one scoreboard entry.
  initial begin
    bit c;
    exp_t e;
    forever begin
      @(posedge clk);
      c = chk;
      #1;
      if (c) begin
        if (q.size() == 0) check("queue_underflow", -1, 12'd1, 12'd0);
        else begin
          e = q.pop_front();
          if (e.tgt == 0) begin
            check("acc_wrap", e.id, {4'h0, a0}, e.a0);
            check("flags_wrap", e.id, {8'h0, f0}, {8'h0, e.f0});
            check("acc_sat", e.id, {4'h0, a1}, e.a1);
            check("flags_sat", e.id, {8'h0, f1}, {8'h0, e.f1});
            if (e.dchk) begin
              check("dbg_wrap", e.id, {4'h0, dd0}, e.d);
              check("dbg_sat", e.id, {4'h0, dd1}, e.d);
            end
          end else begin
            check("acc_w12", e.id, a2, e.a0);
            check("flags_w12", e.id, {8'h0, f2}, {8'h0, e.f0});
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    check("rst_acc0", -1, {4'h0, a0}, 12'h0);
    check("rst_flags0", -1, {8'h0, f0}, 12'h0);
    check("rst_acc2", -1, a2, 12'h0);
    check("rst_flags2", -1, {8'h0, f2}, 12'h0);
    for (int i = 0; i < 8; i++) begin
      da8 = 3'(i);
      #0.1;
      check("rst_dbg0", i, {4'h0, dd0}, 12'h0);
    end
    da8 = 0;
    reset = 1;
    run = 1;
    // add/sub
    s(LI, 3'd3, 8'h03, 4'b0000);
    s(SR, 3'd2, 8'h03, 4'b0000);
    s(LI, 3'd4, 8'hFC, 4'b1000);
    s8(1, SR, 3'd3, 3'd3, 8'hFC, 4'b1000, 8'hFC, 4'b1000, 1, 8'hFC);
    s(LI, 3'd2, 8'h02, 4'b0000);
    s(ADD, 3'd2, 8'h05, 4'b0000);
    s(LI, 3'd2, 8'h02, 4'b0000);
    s(ADD, 3'd3, 8'hFE, 4'b1000);
    // wide constant with a held-off gap
    s(LI, 3'd1, 8'h01, 4'b0000);
    for (int i = 0; i < 3; i++) s8(0, NOT, 3'd5, 3'd0, 8'h01, 4'b0000, 8'h01, 4'b0000, 0, 8'h00);
    s(LIH, 3'd3, 8'h0B, 4'b0000);
    s(LIH, 3'd7, 8'h5F, 4'b0000);
    // positive overflow
    s(LI, 3'd1, 8'h01, 4'b0000);
    s(LIH, 3'd7, 8'h0F, 4'b0000);
    s(LIH, 3'd7, 8'h7F, 4'b0000);
    s8(1, SR, 3'd2, 3'd2, 8'h7F, 4'b0000, 8'h7F, 4'b0000, 1, 8'h7F);
    s8(1, ADD, 3'd2, 3'd0, 8'hFE, 4'b1001, 8'h7F, 4'b0001, 0, 8'h00);
    // sub/cmp
    s(LI, 3'd2, 8'h02, 4'b0001);
    s(SR, 3'd2, 8'h02, 4'b0001);
    s(LI, 3'd3, 8'h03, 4'b0001);
    s(SUB, 3'd2, 8'h01, 4'b0010);
    s(CMP, 3'd2, 8'h01, 4'b1000);
    s8(1, SR, 3'd0, 3'd0, 8'h01, 4'b1000, 8'h01, 4'b1000, 1, 8'h00);
    s(NOT, 3'd0, 8'hFE, 4'b1000);
    s(LR, 3'd3, 8'hFC, 4'b1000);
    s(LI, 3'd0, 8'h00, 4'b0100);
    // negative overflow: 0x80 + 0x80
    s(LI, 3'd2, 8'h02, 4'b0000);
    s(LIH, 3'd0, 8'h10, 4'b0000);
    s(LIH, 3'd0, 8'h80, 4'b1000);
    s(SR, 3'd3, 8'h80, 4'b1000);
    s8(1, ADD, 3'd3, 3'd0, 8'h00, 4'b0111, 8'h80, 4'b1011, 0, 8'h00);
    s(LI, 3'd0, 8'h00, 4'b0111);
    drain();
    // asynchronous reset between edges
    reset = 0;
    #1;
    check("mid_rst_acc0", -1, {4'h0, a0}, 12'h0);
    check("mid_rst_flags0", -1, {8'h0, f0}, 12'h0);
    check("mid_rst_flags1", -1, {8'h0, f1}, 12'h0);
    for (int i = 0; i < 8; i++) begin
      da8 = 3'(i);
      #0.1;
      check("mid_rst_dbg0", i, {4'h0, dd0}, 12'h0);
    end
    @(negedge clk);
    reset = 1;
    // 12-bit variant
    s12(LI, 4'hF, 12'hFFF, 4'b1000);
    s12(LIH, 4'h5, 12'hFF5, 4'b1000);
    s12(SR, 4'h1, 12'hFF5, 4'b1000);
    s12(ADD, 4'h1, 12'hFEA, 4'b1010);
    drain();
    check("queue_empty", -1, 12'(q.size()), 12'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
